mem_lsu: RTL

Load/store unit between the execute stage and the simulation memory port. It takes one memory request at a time and checks alignment. It converts the byte address and size into a doubleword-aligned address, a byte mask and shifted write data, and drives the memory port for exactly one cycle. It then extracts and sign- or zero-extends load data and returns a response to writeback through a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/mem_lsu_if.sv | 44 ++++
 rtl/lsu_align.sv | 50 +++++
 rtl/mem_lsu.sv | 102 ++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states and
// the byte-lane base mask for each size.
package lsu_pkg;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [7:0] size_to_mask(input size_e size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake plus the simulation memory port of the LSU.
// slave = the LSU itself, master = execute/writeback/memory environment.
interface mem_lsu_if;
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_is_store;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [lsu_pkg::XLEN-1:0] req_addr;
  logic [lsu_pkg::XLEN-1:0] req_wdata;
  logic [4:0]               req_rd;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [lsu_pkg::XLEN-1:0] resp_rdata;
  logic [4:0]               resp_rd;
  logic                     resp_misalign;

  logic                     men;
  logic                     mwen;
  logic [lsu_pkg::XLEN-1:0] raddr;
  logic [lsu_pkg::XLEN-1:0] rdata;
  logic [lsu_pkg::XLEN-1:0] waddr;
  logic [lsu_pkg::XLEN-1:0] wdata;
  logic [7:0]               wmask;

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_misalign,
    input  resp_ready,
    output men, mwen, raddr, waddr, wdata, wmask,
    input  rdata
  );

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_misalign,
    output resp_ready,
    input  men, mwen, raddr, waddr, wdata, wmask,
    output rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment check, store mask/data shift and
// load extract with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e            size,
  input  logic [2:0]       off,
  input  logic             uns,
  input  logic [XLEN-1:0]  st_data,
  input  logic [XLEN-1:0]  ld_word,
  output logic             misalign,
  output logic [7:0]       wmask,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  ld_data
);
  logic [5:0]      sh_amt;
  logic [XLEN-1:0] ld_sh;

  function automatic logic [XLEN-1:0] extend(input size_e sz, input logic u,
                                             input logic [XLEN-1:0] d);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    b_s = d[7:0];
    h_s = d[15:0];
    w_s = d[31:0];
    case (sz)
      SZ_B:    if (u) return XLEN'(d[7:0]);  else return XLEN'(b_s);
      SZ_H:    if (u) return XLEN'(d[15:0]); else return XLEN'(h_s);
      SZ_W:    if (u) return XLEN'(d[31:0]); else return XLEN'(w_s);
      default: return d;
    endcase
  endfunction

  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_H:    misalign = off[0];
      SZ_W:    misalign = |off[1:0];
      SZ_D:    misalign = |off;
      default: misalign = 1'b0;
    endcase
  end

  assign sh_amt  = {off, 3'b000};
  assign wmask   = size_to_mask(size) << off;
  assign wdata   = st_data << sh_amt;
  assign ld_sh   = ld_word >> sh_amt;
  assign ld_data = extend(size, uns, ld_sh);
endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: accepts one request, drives the memory port for a single
// registered cycle, then holds the response until writeback takes it.
module mem_lsu
  import lsu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  mem_lsu_if.slave  bus
);
  state_e          state_q, state_nx;
  logic            accept;
  logic            st_q, uns_q;
  size_e           size_q;
  logic [2:0]      off_q;

  size_e           al_size;
  logic [2:0]      al_off;
  logic            al_uns;
  logic            al_misalign;
  logic [7:0]      al_wmask;
  logic [XLEN-1:0] al_wdata, al_ld;

  // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
  assign al_size = (state_q == IDLE) ? size_e'(bus.req_size) : size_q;
  assign al_off  = (state_q == IDLE) ? bus.req_addr[2:0]     : off_q;
  assign al_uns  = (state_q == IDLE) ? bus.req_unsigned      : uns_q;

  lsu_align u_align (
    .size     (al_size),
    .off      (al_off),
    .uns      (al_uns),
    .st_data  (bus.req_wdata),
    .ld_word  (bus.rdata),
    .misalign (al_misalign),
    .wmask    (al_wmask),
    .wdata    (al_wdata),
    .ld_data  (al_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx      = state_q;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = al_misalign ? RESP : ACCESS;
        end
      end
      ACCESS:  state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory-port outputs come straight from flops so the port never sees glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q              <= 1'b0;
      uns_q             <= 1'b0;
      size_q            <= SZ_B;
      off_q             <= 3'd0;
      bus.men           <= 1'b0;
      bus.mwen          <= 1'b0;
      bus.raddr         <= '0;
      bus.waddr         <= '0;
      bus.wdata         <= '0;
      bus.wmask         <= 8'h00;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_rd       <= 5'd0;
      bus.resp_misalign <= 1'b0;
    end else begin
      bus.men        <= accept && !al_misalign;
      bus.mwen       <= accept && !al_misalign && bus.req_is_store;
      bus.resp_valid <= (state_nx == RESP);
      if (accept) begin
        st_q              <= bus.req_is_store;
        uns_q             <= bus.req_unsigned;
        size_q            <= size_e'(bus.req_size);
        off_q             <= bus.req_addr[2:0];
        bus.resp_rd       <= bus.req_rd;
        bus.resp_misalign <= al_misalign;
        bus.resp_rdata    <= '0;
        if (!al_misalign) begin
          bus.raddr <= {bus.req_addr[XLEN-1:3], 3'b000};
          bus.waddr <= {bus.req_addr[XLEN-1:3], 3'b000};
          bus.wdata <= al_wdata;
          bus.wmask <= al_wmask;
        end
      end
      if (state_q == ACCESS && !st_q) bus.resp_rdata <= al_ld;
    end
  end
endmodule
